// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the CDB between RS, branch and SLB producers via one-deep holding buffers.
// CDB_FIXED_PRIO_EN selects fixed priority branch > SLB > RS instead of round-robin.
module cdb_arbiter #(
  parameter int ENTRY_W = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               flush_in,
  input  logic               rs_valid_in,
  input  logic [ENTRY_W-1:0] rs_entry_in,
  input  logic [31:0]        rs_value_in,
  input  logic               br_valid_in,
  input  logic [ENTRY_W-1:0] br_entry_in,
  input  logic [31:0]        br_value_in,
  input  logic               slb_valid_in,
  input  logic [ENTRY_W-1:0] slb_entry_in,
  input  logic [31:0]        slb_value_in,
  output logic               rs_ready_out,
  output logic               br_ready_out,
  output logic               slb_ready_out,
  output logic               cdb_valid_out,
  output logic [ENTRY_W-1:0] cdb_entry_out,
  output logic [31:0]        cdb_value_out,
  output logic [1:0]         cdb_src_out
);
  logic [2:0] in_v, buf_v, grant, ready, acc;
  logic [ENTRY_W-1:0] in_e [3];
  logic [ENTRY_W-1:0] buf_e [3];
  logic [31:0] in_d [3];
  logic [31:0] buf_d [3];
  logic [1:0] win;
  logic any;
  assign in_v = {slb_valid_in, br_valid_in, rs_valid_in};
  assign in_e = '{rs_entry_in, br_entry_in, slb_entry_in};
  assign in_d = '{rs_value_in, br_value_in, slb_value_in};
`ifdef CDB_FIXED_PRIO_EN
  assign win = buf_v[1] ? 2'd1 : buf_v[2] ? 2'd2 : 2'd0;
`else
  logic [1:0] last, c1, c2;
  assign c1  = last == 2'd2 ? 2'd0 : last + 2'd1;
  assign c2  = c1 == 2'd2 ? 2'd0 : c1 + 2'd1;
  assign win = buf_v[c1] ? c1 : buf_v[c2] ? c2 : last;
`endif
  assign any   = |buf_v;
  assign grant = any ? 3'b001 << win : 3'b000;
  // Ready never looks at valid, so no valid-to-output path exists.
  assign ready = {3{rdy_in & ~flush_in}} & (~buf_v | grant);
  always_comb begin
    acc = '0;
    for (int i = 0; i < 3; i++) acc[i] = in_v[i] & ready[i] & |in_e[i];
  end
  assign rs_ready_out  = ready[0];
  assign br_ready_out  = ready[1];
  assign slb_ready_out = ready[2];
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      buf_v         <= '0;
      cdb_valid_out <= 1'b0;
      cdb_entry_out <= '0;
      cdb_value_out <= '0;
      cdb_src_out   <= '0;
      for (int i = 0; i < 3; i++) begin
        buf_e[i] <= '0;
        buf_d[i] <= '0;
      end
`ifndef CDB_FIXED_PRIO_EN
      last <= 2'd2;
`endif
    end else if (rdy_in) begin
      if (flush_in) begin
        buf_v         <= '0;
        cdb_valid_out <= 1'b0;
      end else begin
        cdb_valid_out <= any;
        if (any) begin
          cdb_entry_out <= buf_e[win];
          cdb_value_out <= buf_d[win];
          cdb_src_out   <= win;
`ifndef CDB_FIXED_PRIO_EN
          last <= win;
`endif
        end
        for (int i = 0; i < 3; i++) begin
          if (acc[i]) begin
            buf_v[i] <= 1'b1;
            buf_e[i] <= in_e[i];
            buf_d[i] <= in_d[i];
          end else if (grant[i]) begin
            buf_v[i] <= 1'b0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: randomized and directed checks of cdb_arbiter against a behavioural model.
module tb_cdb_arbiter;
  logic clk_in = 0, rst_in = 0, rdy_in = 1, flush_in = 0;
  logic v [3];
  logic [3:0] e [3];
  logic [31:0] d [3];
  logic [2:0] rdy_o;
  logic cdb_valid_out;
  logic [3:0] cdb_entry_out;
  logic [31:0] cdb_value_out;
  logic [1:0] cdb_src_out;
  int total = 0, bad = 0, n7 = 0, n0 = 0;
  bit mv [3];
  logic [3:0] me [3];
  logic [31:0] md [3];
  int mlast;
  bit mcv;
  logic [3:0] mce;
  logic [31:0] mcd;
  logic [1:0] mcs;

  cdb_arbiter #(.ENTRY_W(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .rs_valid_in(v[0]), .rs_entry_in(e[0]), .rs_value_in(d[0]),
    .br_valid_in(v[1]), .br_entry_in(e[1]), .br_value_in(d[1]),
    .slb_valid_in(v[2]), .slb_entry_in(e[2]), .slb_value_in(d[2]),
    .rs_ready_out(rdy_o[0]), .br_ready_out(rdy_o[1]), .slb_ready_out(rdy_o[2]),
    .cdb_valid_out(cdb_valid_out), .cdb_entry_out(cdb_entry_out),
    .cdb_value_out(cdb_value_out), .cdb_src_out(cdb_src_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick();
`ifdef CDB_FIXED_PRIO_EN
    int order [3] = '{1, 2, 0};
    foreach (order[k]) if (mv[order[k]]) return order[k];
`else
    for (int k = 1; k <= 3; k++) if (mv[(mlast + k) % 3]) return (mlast + k) % 3;
`endif
    return -1;
  endfunction

  task automatic model_reset();
    foreach (mv[i]) mv[i] = 0;
    mlast = 2;
    mcv = 0; mce = 0; mcd = 0; mcs = 0;
  endtask

  task automatic drive(input int i, input logic vv, input logic [3:0] ee, input logic [31:0] dd);
    v[i] = vv; e[i] = ee; d[i] = dd;
  endtask

  task automatic idle();
    for (int i = 0; i < 3; i++) drive(i, 0, 0, 0);
  endtask

  // Inputs are driven by the caller just after an edge; this checks ready, advances one edge, checks the CDB.
  task automatic step();
    int w;
    bit acc [3];
    bit mr;
    #1;
    w = pick();
    for (int i = 0; i < 3; i++) begin
      mr = rdy_in && !flush_in && (!mv[i] || w == i);
      check($sformatf("ready%0d", i), rdy_o[i], mr);
      acc[i] = mr && v[i] && e[i] != 0;
    end
    if (rdy_in && cdb_valid_out) begin
      if (cdb_entry_out == 7) n7++;
      if (cdb_entry_out == 0) n0++;
    end
    @(posedge clk_in);
    if (rdy_in) begin
      if (flush_in) begin
        foreach (mv[i]) mv[i] = 0;
        mcv = 0;
      end else begin
        mcv = w >= 0;
        if (w >= 0) begin
          mce = me[w]; mcd = md[w]; mcs = 2'(w); mv[w] = 0; mlast = w;
        end
        for (int i = 0; i < 3; i++)
          if (acc[i]) begin mv[i] = 1; me[i] = e[i]; md[i] = d[i]; end
      end
    end
    #1;
    check("cdb_valid", cdb_valid_out, mcv);
    if (mcv) begin
      check("cdb_entry", cdb_entry_out, mce);
      check("cdb_value", cdb_value_out, mcd);
      check("cdb_src", cdb_src_out, mcs);
    end
  endtask

  task automatic do_reset();
    rst_in = 0; rdy_in = 1; flush_in = 0;
    idle();
    model_reset();
    #2;
    check("rst_valid", cdb_valid_out, 0);
    check("rst_entry", cdb_entry_out, 0);
    check("rst_value", cdb_value_out, 0);
    check("rst_src", cdb_src_out, 0);
    check("rst_ready", rdy_o, 3'b111);
    @(negedge clk_in);
    rst_in = 1;
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    idle();
    do_reset();
    // single RS result
    drive(0, 1, 3, 32'h12345678);
    step();
    idle();
    step();
    check("single_valid", cdb_valid_out, 1);
    check("single_entry", cdb_entry_out, 3);
    check("single_value", cdb_value_out, 32'h12345678);
    check("single_src", cdb_src_out, 0);
    // asynchronous reset while a broadcast is live
    #2 rst_in = 0;
    #1;
    check("async_valid", cdb_valid_out, 0);
    check("async_entry", cdb_entry_out, 0);
    do_reset();
    // all three stream continuously
    for (int k = 0; k < 7; k++) begin
      for (int i = 0; i < 3; i++) drive(i, 1, 4'(1 + i * 4 + (k % 4)), $urandom);
      step();
      if (k > 0) begin
`ifdef CDB_FIXED_PRIO_EN
        check("stream_src", cdb_src_out, 1);
        check("stream_rs_starved", rdy_o[0], 0);
`else
        check("stream_src", cdb_src_out, (k - 1) % 3);
`endif
      end
    end
    // flush with full buffers and a live broadcast; flush-cycle inputs are dropped
    check("pre_flush_valid", cdb_valid_out, 1);
    flush_in = 1;
    for (int i = 0; i < 3; i++) drive(i, 1, 4'hf, 32'hdead);
    step();
    check("flush_valid", cdb_valid_out, 0);
    flush_in = 0;
    idle();
    drive(1, 1, 5, 32'h55);
    step();
    idle();
    step();
    check("post_flush_entry", cdb_entry_out, 5);
    check("post_flush_src", cdb_src_out, 1);
    step();
    // stall with entry 7 on the bus; entry-0 request must never appear
    n7 = 0; n0 = 0;
    drive(0, 1, 7, 32'h77);
    step();
    idle();
    step();
    check("stall_entry", cdb_entry_out, 7);
    rdy_in = 0;
    drive(1, 1, 0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      flush_in = k[0];
      step();
      check("stall_ready", rdy_o, 0);
    end
    rdy_in = 1; flush_in = 0;
    step();
    step();
    idle();
    step();
    check("stall_once", n7, 1);
    check("no_zero_tag", n0, 0);
    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      rdy_in = $urandom_range(0, 9) != 0;
      flush_in = $urandom_range(0, 19) == 0;
      for (int i = 0; i < 3; i++)
        drive(i, $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0 ? 4'd0 : 4'($urandom_range(1, 15)), $urandom);
      step();
    end
    rdy_in = 1; flush_in = 0;
    idle();
    for (int k = 0; k < 4; k++) step();
    check("drained", cdb_valid_out, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

- Shares the single common data bus (CDB) into the reorder buffer between three result producers: RS/ALU, branch unit and store/load buffer (SLB).
- Each producer has a one-deep holding buffer with a valid/ready handshake.
- One winner per cycle is chosen by round-robin, or by fixed priority when configured.
- The winner is driven as a registered broadcast (entry, value, source) that the ROB and reservation stations sample.
- The whole block is cleared on a pipeline flush.

## Interface
Parameters:
- ENTRY_W, 4, width of ROB entry tag; tag 0 means "no entry".

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  asynchronous, active-low reset.
- rdy_in  input  1  global enable; when low, all state holds.
- flush_in  input  1  misprediction flush; synchronous, 1 cycle.
- rs_valid_in / br_valid_in / slb_valid_in  input  1  producer has a result.
- rs_entry_in / br_entry_in / slb_entry_in  input  ENTRY_W  ROB tag of the result.
- rs_value_in / br_value_in / slb_value_in  input  32  result value.
- rs_ready_out / br_ready_out / slb_ready_out  output  1  holding buffer can accept this cycle.
- cdb_valid_out  output  1  broadcast valid; registered.
- cdb_entry_out  output  ENTRY_W  broadcast tag; registered.
- cdb_value_out  output  32  broadcast value; registered.
- cdb_src_out  output  2  source of the broadcast: 0 RS, 1 branch, 2 SLB.

## Operation
Source index:
- RS = 0, branch = 1, SLB = 2.

Holding buffer (per source):
- Each buffer holds `buf_v`, `buf_entry` and `buf_value`.
- ready_i = rdy_in & !flush_in & (!buf_v_i | grant_i). This is combinational from buffer state and grant only, never from valid_i.
- Accept when valid_i & ready_i: the buffer loads at the next edge.
- If the buffer is granted and refilled in the same cycle, the new data wins and buf_v stays 1.
- A request with entry tag 0 is dropped: ready stays as computed, nothing is buffered.

Arbitration:
- Combinational over buf_v[2:0].
- Round-robin pointer `last` holds the last granted index. Search order is last+1, last+2, last+3, each mod 3. `last` updates only on a grant.
- At most one grant_i per cycle. No grant when no buffer is valid.

Broadcast register (loads at each edge where rdy_in=1 and flush_in=0):
- With a winner: cdb_valid=1, and entry/value/src are taken from the winning buffer; that buffer clears unless refilled.
- With no winner: cdb_valid=0. Entry, value and src hold their last values and are don't-care for consumers.

Flush:
- Edge with flush_in=1 (and rdy_in=1): all buf_v=0, cdb_valid=0, `last` unchanged.
- Inputs presented in the flush cycle are not accepted.

rdy_in=0:
- Buffers, `last` and the broadcast registers all hold.
- All ready outputs are 0.
- A broadcast pending at the stall is therefore seen exactly once, at the first edge with rdy_in=1.

Reset (rst_in=0, asynchronous):
- buf_v=0 and `last`=2, so RS is first in order.
- cdb_valid_out=0, cdb_entry_out=0, cdb_value_out=0, cdb_src_out=0.
- Ready outputs follow the ready formula, i.e. they equal rdy_in & !flush_in.

## Timing
- Request accepted at edge N. Earliest broadcast is visible after edge N+1 (1 cycle latency through the buffer), then held for one cycle.
- Throughput: one broadcast per cycle total. Per source, one per cycle when that source is the only one requesting; back-to-back accept and grant with no bubble.
- Worst-case wait under round-robin with all three busy: 2 cycles between grants to the same source.
- Flush and rdy_in=0 in the same cycle: rdy_in=0 dominates and everything holds; the flush is not applied. The flush producer must hold flush_in until rdy_in=1.
- No combinational path from any *_valid_in to any output.

## Configuration
- CDB_FIXED_PRIO_EN defined: fixed priority branch > SLB > RS. The `last` pointer is not implemented. RS can be starved when the others stream continuously.
- CDB_FIXED_PRIO_EN undefined (default): round-robin as described above.

## Test plan
- Reset: rst_in low mid-broadcast → cdb_valid_out=0, cdb_entry_out=0 immediately (asynchronous); all ready outputs=1 once rdy_in=1 after release.
- Single source: RS sends entry 3 / value 0x12345678 at edge N → after edge N+1, cdb_valid=1, entry=3, value=0x12345678, src=0; after edge N+2, cdb_valid=0.
- All three stream continuously from reset (round-robin) → src sequence 0,1,2,0,1,2; each ready pulses once per 3 cycles; no tag lost or duplicated.
- Same stream with CDB_FIXED_PRIO_EN → src=1 every cycle; rs_ready_out stays 0 after the first accept.
- Flush with all three buffers full and cdb_valid=1 → after the flush edge, cdb_valid=0; the next valid broadcast has a tag presented after the flush.
- rdy_in low for 5 cycles while a broadcast of entry 7 is valid → entry 7 is broadcast exactly once at the first rdy_in-high edge; ready outputs are 0 throughout the stall; an entry-0 request is never broadcast.
